fp_div: RTL
===========

# fp_div

Iterative IEEE-754 single-precision divider for the systolic accelerator datapath. It computes `a / b` and is the inverse-direction counterpart of the pipelined `fp_mult`. It uses the same number-format policy as `fp_mult`:
- denormals flush to zero;
- the quotient is truncated, not rounded;
- out-of-range exponents saturate.

It is a multi-cycle unit with valid/ready handshakes on both sides, intended for normalization and scaling stages that sit downstream of the PE array.

## Interface
- No parameters; format is fixed fp32.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `a` input 32: dividend, fp32.
- `b` input 32: divisor, fp32.
- `in_valid` input 1: operands present.
- `in_ready` output 1: unit can accept operands; high only in IDLE.
- `result` output 32: quotient, fp32; held stable while `out_valid` is high.
- `out_valid` output 1: `result` is valid.
- `out_ready` input 1: consumer accepts `result`.

## Operation
- **Input accept:** occurs on a rising edge with `in_valid && in_ready`. The unit captures sign, exponent and 24-bit mantissa (hidden bit set) of both operands.
- **Special cases** are resolved at accept and go straight to DONE. They are evaluated in this priority order:
  - either exp==FF with mantissa!=0 (NaN) → 0x7FC00000;
  - both Inf, or both zero → 0x7FC00000;
  - `a` Inf → {s,FF,0};
  - `b` Inf → 0x00000000;
  - `a` zero → 0x00000000;
  - `b` zero → {s,FF,0}.
- Zero means exp==00, regardless of mantissa (denormal flush). `s` = sign_a ^ sign_b.
- **Normal path:**
  - Exponent: 10-bit signed, `exp = ea − eb + 127`.
  - Mantissa: restoring division with a 25-bit remainder initialized to `ma`.
  - Per iteration: if `rem >= mb`, set the q bit to 1 and do `rem -= mb`; then `rem <<= 1`.
  - 25 iterations produce `q[24:0]`, MSB first.
- **Normalize:**
  - If `q[24]`: `frac = q[23:1]`, exp unchanged.
  - Else: `frac = q[22:0]`, `exp −= 1`.
- **Range check** after normalize:
  - exp ≥ 255 → {s,FF,0};
  - exp ≤ 0 → 0x00000000;
  - else {s, exp[7:0], frac}.
- **FSM:**
  - IDLE → DIVIDE on accept with normal operands.
  - IDLE → DONE on accept with special operands.
  - DIVIDE → NORM when the iteration counter reaches 24; the counter runs 0..24.
  - NORM → DONE.
  - DONE → IDLE on `out_ready`.
- `out_valid` is high exactly in DONE.

## Timing
- **Reset values:**
  - state = IDLE, so `in_ready` = 1 while `rst` is low.
  - `out_valid` = 0.
  - `result` = 0.
  - counter and remainder = 0.
- **Normal latency:** accept at edge T; DIVIDE occupies edges T+1..T+25; NORM registers `result` at edge T+26. `out_valid` is high from T+26.
- **Special latency:** `result` is registered at the accept edge T, and `out_valid` is high from T.
- **Output hold:**
  - `result` and `out_valid` stay constant until an edge with `out_ready` high; that edge returns the unit to IDLE.
  - `in_ready` rises one cycle after the output handshake, so there is no input bypass.
  - Minimum normal throughput is 28 cycles per op with `out_ready` tied high.
- **Ignored inputs:** `in_valid` while not in IDLE is ignored, and operands are not sampled.
- **Reset mid-operation:** the in-flight op is discarded and `out_valid` drops immediately (asynchronous). The unit restarts in IDLE.
- `out_ready` asserted outside DONE has no effect.

## Structure
- **Package `fp_pkg`** holds:
  - the `fp32_t` struct {sign, exp[7:0], frac[22:0]};
  - constants `FP_BIAS`=127, `FP_QNAN`=32'h7FC00000, `FP_EXP_MAX`=8'hFF;
  - the state enum `div_state_t`.
- **Sub-module `fp_div_core`:** the 25-cycle restoring mantissa divider, with `start`/`done` and 24-bit inputs producing a 25-bit quotient.
- The top level contains the FSM, special-case decode and normalize/pack logic.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) → 0x40400000; `out_valid` high exactly 26 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAA (truncated). Then 0x40400000 / 0x40400000 → 0x3F800000, exercising the `q[24]=1` path.
- Special cases, each with `out_valid` in the accept cycle:
  - 0xBF800000 / 0x00000000 → 0xFF800000;
  - 0/0 → 0x7FC00000;
  - 0x00000000 / 0x40000000 → 0x00000000;
  - 0x7FC00001 / 0x3F800000 → 0x7FC00000.
- Range saturation:
  - overflow: 0x7F000000 / 0x3E800000 → 0x7F800000;
  - underflow: 0x00800000 / 0x40000000 → 0x00000000.
- Backpressure: hold `out_ready` low 10 cycles after `out_valid`. Expected:
  - `result` stable and `in_ready` low throughout;
  - an `in_valid` pulse during the hold is ignored;
  - release → IDLE the next cycle.
- Assert `rst` low at DIVIDE iteration 10 → `out_valid`=0 and `in_ready`=1 immediately. A new op of 8/2 after release → 0x40800000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared fp32 definitions for the accelerator floating-point units.
package fp_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   localparam int          FP_BIAS    = 127;
   localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
   localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
   localparam int          DIV_ITERS  = 25;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIVIDE,
      ST_NORM,
      ST_DONE
   } div_state_t;

   // Denormals are flushed, so any zero exponent counts as zero.
   function automatic logic fp_is_zero(input fp32_t x);
      return x.exp == 8'h00;
   endfunction

   function automatic logic fp_is_inf(input fp32_t x);
      return (x.exp == FP_EXP_MAX) && (x.frac == 23'd0);
   endfunction

   function automatic logic fp_is_nan(input fp32_t x);
      return (x.exp == FP_EXP_MAX) && (x.frac != 23'd0);
   endfunction

   function automatic fp32_t fp_inf(input logic s);
      fp32_t r;
      r.sign = s;
      r.exp  = FP_EXP_MAX;
      r.frac = '0;
      return r;
   endfunction

endpackage

// File: rtl/fp_div_core.sv
// Restoring mantissa divider: 25 iterations, one quotient bit per cycle, MSB first.
module fp_div_core import fp_pkg::*; (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [23:0] dividend,
   input  logic [23:0] divisor,
   output logic        done,
   output logic [24:0] quot
);

   localparam logic [4:0] LAST = 5'(DIV_ITERS - 1);

   logic [24:0] rem;
   logic [24:0] rem_sub;
   logic [24:0] rem_nxt;
   logic [23:0] dvs;
   logic [4:0]  cnt;
   logic        busy;
   logic        ge;

   // Trial subtraction; the remainder stays below 2*divisor so the shift never overflows.
   always_comb begin
      ge      = rem >= {1'b0, dvs};
      rem_sub = ge ? (rem - {1'b0, dvs}) : rem;
      rem_nxt = rem_sub << 1;
   end

   // High during the cycle whose edge writes the last quotient bit.
   assign done = busy && (cnt == LAST);

   // Iteration state: load on start, then shift in one quotient bit per cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem  <= '0;
         dvs  <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         quot <= '0;
      end else if (start) begin
         rem  <= {1'b0, dividend};
         dvs  <= divisor;
         cnt  <= '0;
         busy <= 1'b1;
         quot <= '0;
      end else if (busy) begin
         rem  <= rem_nxt;
         quot <= {quot[23:0], ge};
         cnt  <= cnt + 5'd1;
         if (cnt == LAST) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/fp_div.sv
// Iterative fp32 divider: special-case decode, FSM, normalize and pack.
// Denormals flush to zero, quotient truncates, exponent saturates.
module fp_div import fp_pkg::*; (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] result,
   output logic        out_valid,
   input  logic        out_ready
);

   div_state_t state, state_nxt;

   fp32_t              fa, fb;
   logic               sign_in;
   logic               special;
   logic [31:0]        spec_res;
   logic signed [9:0]  exp_in;

   logic               accept;
   logic               start;
   logic               core_done;
   logic [24:0]        quot;

   logic               sign_q;
   logic signed [9:0]  exp_q;
   logic signed [9:0]  exp_n;
   logic [22:0]        frac_n;
   logic [31:0]        packed_res;

   assign fa      = a;
   assign fb      = b;
   assign sign_in = fa.sign ^ fb.sign;
   assign exp_in  = 10'(fa.exp) - 10'(fb.exp) + 10'(FP_BIAS);

   // Special operand decode, in priority order; special=0 means the normal path.
   always_comb begin
      special  = 1'b1;
      spec_res = '0;
      if (fp_is_nan(fa) || fp_is_nan(fb))
         spec_res = FP_QNAN;
      else if ((fp_is_inf(fa) && fp_is_inf(fb)) || (fp_is_zero(fa) && fp_is_zero(fb)))
         spec_res = FP_QNAN;
      else if (fp_is_inf(fa))
         spec_res = fp_inf(sign_in);
      else if (fp_is_inf(fb))
         spec_res = '0;
      else if (fp_is_zero(fa))
         spec_res = '0;
      else if (fp_is_zero(fb))
         spec_res = fp_inf(sign_in);
      else
         special = 1'b0;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      start     = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               if (special) begin
                  state_nxt = ST_DONE;
               end else begin
                  start     = 1'b1;
                  state_nxt = ST_DIVIDE;
               end
            end
         end
         ST_DIVIDE: if (core_done) state_nxt = ST_NORM;
         ST_NORM:   state_nxt = ST_DONE;
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default:   state_nxt = ST_IDLE;
      endcase
   end

   fp_div_core u_core (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dividend ({1'b1, fa.frac}),
      .divisor  ({1'b1, fb.frac}),
      .done     (core_done),
      .quot     (quot)
   );

   // Normalize the 25-bit quotient and apply the exponent range check.
   always_comb begin
      if (quot[24]) begin
         exp_n  = exp_q;
         frac_n = quot[23:1];
      end else begin
         exp_n  = exp_q - 10'sd1;
         frac_n = quot[22:0];
      end
      if (exp_n >= 10'sd255)
         packed_res = fp_inf(sign_q);
      else if (exp_n <= 10'sd0)
         packed_res = '0;
      else
         packed_res = {sign_q, exp_n[7:0], frac_n};
   end

   // Operand sign/exponent capture and result register (held through DONE).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result <= '0;
         sign_q <= 1'b0;
         exp_q  <= '0;
      end else begin
         if (accept) begin
            sign_q <= sign_in;
            exp_q  <= exp_in;
         end
         if (accept && special)
            result <= spec_res;
         else if (state == ST_NORM)
            result <= packed_res;
      end
   end

endmodule
